alu_request_sequencer: RTL and testbench

- Upstream front-end for the 8-bit add/sub/Booth-multiply/divide unit.
- Accepts operation requests from a host over a valid/ready handshake and registers the operands.
- Raises the control unit's begin_sig and steers operands onto the datapath input bus when the control unit asks for them.
- Captures the result halves from the output bus on the load strobes, waits for end_sig, then returns the result on a valid/ready response channel; a watchdog covers a hung operation.

---
 rtl/alu_request_sequencer.sv | 118 +++++++++++
 tb/tb_alu_request_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_request_sequencer.sv
`timescale 1ns/1ps
// Host-facing request/response front-end for the add/sub/mul/div control unit.
// Optional macro DIV_ZERO_CHECK_EN answers divide-by-zero locally without starting the unit.
module alu_request_sequencer #(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [1:0]         req_op,
  input  logic [WIDTH-1:0]   req_x,
  input  logic [WIDTH-1:0]   req_y,
  output logic               begin_sig,
  output logic [1:0]         op,
  input  logic               ld_x,
  input  logic               ld_y,
  output logic [WIDTH-1:0]   inbus,
  input  logic [WIDTH-1:0]   outbus,
  input  logic               res_ld_hi,
  input  logic               res_ld_lo,
  input  logic               end_sig,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic               rsp_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state;
  logic [WIDTH-1:0] x_reg, y_reg, hi_reg, lo_reg;
  logic [WD_W-1:0]  watchdog;
  logic             accept, div_zero, capture;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign rsp_data  = {hi_reg, lo_reg};
  assign accept    = req_valid & req_ready;
  assign capture   = (state == START) || (state == BUSY);

`ifdef DIV_ZERO_CHECK_EN
  assign div_zero = (req_op == 2'b11) && (req_y == '0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    inbus = '0;
    if (ld_x)      inbus = x_reg;
    else if (ld_y) inbus = y_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      begin_sig <= 1'b0;
      op        <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      rsp_err   <= 1'b0;
      watchdog  <= '0;
    end else begin
      begin_sig <= 1'b0;
      if (capture) begin
        if (res_ld_hi) hi_reg <= outbus;
        if (res_ld_lo) lo_reg <= outbus;
      end
      // Timeout clearing below must come after capture so it wins in the same cycle.
      case (state)
        IDLE: if (accept) begin
          op      <= req_op;
          x_reg   <= req_x;
          y_reg   <= req_y;
          hi_reg  <= '0;
          lo_reg  <= '0;
          rsp_err <= 1'b0;
          if (div_zero) begin
            hi_reg  <= '1;
            lo_reg  <= '1;
            rsp_err <= 1'b1;
            state   <= RESP;
          end else begin
            begin_sig <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          watchdog <= '0;
          state    <= BUSY;
        end
        BUSY: begin
          watchdog <= watchdog + WD_W'(1);
          if (end_sig) begin
            state <= RESP;
          end else if (watchdog == WD_LAST) begin
            state   <= RESP;
            rsp_err <= 1'b1;
            hi_reg  <= '0;
            lo_reg  <= '0;
          end
        end
        RESP: if (rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_request_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench: a stub control unit plus a transaction-level result model.
module tb_alu_request_sequencer;
  localparam int W = 8;
  localparam int T = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         req_valid, req_ready;
  logic [1:0]   req_op, op;
  logic [W-1:0] req_x, req_y, inbus, outbus;
  logic         begin_sig, ld_x, ld_y, res_ld_hi, res_ld_lo, end_sig;
  logic         rsp_valid, rsp_ready, rsp_err;
  logic [2*W-1:0] rsp_data;

  alu_request_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_x(req_x), .req_y(req_y), .begin_sig(begin_sig), .op(op),
    .ld_x(ld_x), .ld_y(ld_y), .inbus(inbus), .outbus(outbus),
    .res_ld_hi(res_ld_hi), .res_ld_lo(res_ld_lo), .end_sig(end_sig),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit             chk_en = 1'b0;
  logic           e_req_ready, e_begin, e_rsp_valid, e_err;
  logic [1:0]     e_op;
  logic [W-1:0]   e_inbus;
  logic [2*W-1:0] e_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result the stub datapath produces for a request.
  function automatic logic [2*W-1:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    case (o)
      2'd0:    return (2*W)'(x) + (2*W)'(y);
      2'd1:    return (2*W)'(x) - (2*W)'(y);
      2'd2:    return (2*W)'(x) * (2*W)'(y);
      default: return (y == '0) ? '1 : {x % y, x / y};
    endcase
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", req_ready, e_req_ready);
      chk("begin_sig", begin_sig, e_begin);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      chk("op", op, e_op);
      chk("inbus", inbus, e_inbus);
      if (e_rsp_valid) begin
        chk("rsp_data", rsp_data, e_data);
        chk("rsp_err", rsp_err, e_err);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    ld_x = 1'b0; ld_y = 1'b0; res_ld_hi = 1'b0; res_ld_lo = 1'b0; end_sig = 1'b0;
    outbus = W'($urandom);
    e_inbus = '0;
  endtask

  // e_cyc: BUSY cycle index on which end_sig fires (-1 = never).
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input int e_cyc, input bit both_res, input int bp, output logic [2*W-1:0] got);
    logic [2*W-1:0] res, expd;
    bit dz, tmo;
    res = model(o, x, y);
    tmo = 1'b0;
`ifdef DIV_ZERO_CHECK_EN
    dz = (o == 2'd3) && (y == '0);
`else
    dz = 1'b0;
`endif
    next_cycle();
    e_req_ready = 1'b1; e_begin = 1'b0; e_rsp_valid = 1'b0;
    req_valid = 1'b1; req_op = o; req_x = x; req_y = y;
    next_cycle();
    e_op = o; e_req_ready = 1'b0;
    end_sig = 1'($urandom_range(0, 1));
    if (!dz) begin
      e_begin = 1'b1;
      next_cycle();
      e_begin = 1'b0;
      expd = both_res ? {res[2*W-1:W], res[2*W-1:W]} : res;
      for (int b = 0; b < T; b++) begin
        case (b)
          0: begin ld_x = 1'b1; ld_y = 1'($urandom_range(0, 1)); e_inbus = x; end
          1: begin ld_y = 1'b1; e_inbus = y; end
          2: begin res_ld_hi = 1'b1; outbus = res[2*W-1:W]; res_ld_lo = both_res; end
          3: if (!both_res) begin res_ld_lo = 1'b1; outbus = res[W-1:0]; end
          default: ;
        endcase
        if (b == e_cyc) begin end_sig = 1'b1; break; end
        if (b == T-1) begin tmo = 1'b1; break; end
        next_cycle();
      end
      if (tmo) expd = '0;
    end else begin
      expd = '1;
    end
    for (int r = 0; r <= bp; r++) begin
      if (!(r == 0 && dz)) next_cycle();
      e_rsp_valid = 1'b1; e_begin = 1'b0; e_data = expd; e_err = tmo || dz;
      res_ld_hi = 1'($urandom_range(0, 1));
      res_ld_lo = 1'($urandom_range(0, 1));
      end_sig   = 1'($urandom_range(0, 1));
      rsp_ready = (r == bp);
      if (r == 0) got = rsp_data;
    end
    next_cycle();
    e_rsp_valid = 1'b0; e_req_ready = 1'b1;
  endtask

  initial begin
    logic [2*W-1:0] got;
    reset = 1'b0; req_valid = 1'b0; req_op = '0; req_x = '0; req_y = '0;
    ld_x = 1'b0; ld_y = 1'b0; outbus = '0; res_ld_hi = 1'b0; res_ld_lo = 1'b0;
    end_sig = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_begin", begin_sig, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_op", op, 2'd0);
    chk("rst_data", rsp_data, 16'h0000);
    chk("rst_err", rsp_err, 1'b0);
    reset = 1'b1;
    e_req_ready = 1'b1; e_begin = 1'b0; e_rsp_valid = 1'b0; e_op = 2'd0; e_inbus = '0;
    e_data = '0; e_err = 1'b0;
    chk_en = 1'b1;

    do_op(2'd2, 8'h12, 8'h34, 5, 1'b0, 0, got);
    chk("mul_data", got, 16'h03A8);
    do_op(2'd0, 8'h7F, 8'h81, 4, 1'b0, 10, got);
    chk("backpressure_data", got, 16'h0100);
    do_op(2'd1, 8'h09, 8'h04, -1, 1'b0, 2, got);
    chk("timeout_data", got, 16'h0000);
    do_op(2'd2, 8'h03, 8'h05, T-1, 1'b0, 0, got);
    chk("end_at_timeout_data", got, 16'h000F);
    do_op(2'd1, 8'h10, 8'h20, 3, 1'b1, 0, got);
    chk("both_strobes_data", got, 16'hFFFF);
    do_op(2'd3, 8'h64, 8'h07, 6, 1'b0, 1, got);
    chk("div_data", got, 16'h020E);
    do_op(2'd3, 8'h40, 8'h00, -1, 1'b0, 0, got);
`ifdef DIV_ZERO_CHECK_EN
    chk("divzero_data", got, 16'hFFFF);
`else
    chk("divzero_data", got, 16'h0000);
`endif

    // Reset while BUSY.
    next_cycle();
    req_valid = 1'b1; req_op = 2'd2; req_x = 8'h21; req_y = 8'h02;
    next_cycle();
    e_op = 2'd2; e_req_ready = 1'b0; e_begin = 1'b1;
    next_cycle();
    e_begin = 1'b0; ld_x = 1'b1; e_inbus = 8'h21;
    next_cycle();
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    chk("midrst_op", op, 2'd0);
    chk("midrst_begin", begin_sig, 1'b0);
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
    e_op = 2'd0; e_req_ready = 1'b1; e_begin = 1'b0; e_rsp_valid = 1'b0;
    chk_en = 1'b1;
    do_op(2'd0, 8'h05, 8'h03, 4, 1'b0, 0, got);
    chk("post_reset_add", got, 16'h0008);

    for (int n = 0; n < 40; n++) begin
      logic [1:0] o;
      logic [W-1:0] x, y;
      int ec;
      o = 2'($urandom_range(0, 3));
      x = W'($urandom);
      y = W'($urandom);
      if (o == 2'd3 && y == '0) y = 8'h01;
      ec = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(3, T-1));
      repeat ($urandom_range(0, 2)) next_cycle();
      do_op(o, x, y, ec, ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)), got);
    end

    next_cycle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
